cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between NUM_REQ functional-unit completion ports.
- Each requester hands its result over through a valid/ready handshake into a one-entry holding slot.
- A round-robin arbiter picks one held result per cycle and broadcasts it on registered CDB outputs.
- The CDB feeds the complete stage, the ROB and RS wakeup. The one-hot source ID lets dispatch free the originating FU.

Parameters:
- NUM_REQ, 4, number of completion requesters (FU ports), >= 2.
- XLEN, 32, result data width.
- PREG_W, 6, physical register index width (0 = no destination).
- ROB_W, 5, ROB index width.
- REQ_IDX_W, $clog2(NUM_REQ), requester index width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- squash  in  1  synchronous flush (branch mispredict); drops all held and pending results
- req_valid  in  NUM_REQ  requester i offers a result
- req_ready  out  NUM_REQ  arbiter accepts from requester i this cycle
- req_dest_idx  in  NUM_REQ x PREG_W  physical destination per requester
- req_data  in  NUM_REQ x XLEN  result per requester
- req_rob_idx  in  NUM_REQ x ROB_W  ROB entry per requester
- cdb_valid  out  1  broadcast valid (ROB completion)
- cdb_wr_en  out  1  cdb_valid and cdb_dest_idx != 0 (regfile write / wakeup)
- cdb_dest_idx  out  PREG_W  broadcast physical destination
- cdb_data  out  XLEN  broadcast data
- cdb_rob_idx  out  ROB_W  broadcast ROB index
- cdb_src_oh  out  NUM_REQ  one-hot source of the broadcast (FU free); 0 when cdb_valid=0

Behaviour:
- Reset (async, active-high):
  - All hold_valid, cdb_* outputs and rr_ptr are cleared to 0.
  - req_ready reads 0 while reset is asserted.
- Holding slots: one slot per requester, holding hold_valid, dest, data and rob.
- Handshake:
  - req_ready[i] = ~squash & ~reset & (~hold_valid[i] | grant[i]).
  - A transfer happens when req_valid[i] & req_ready[i]. The slot loads at the next edge.
  - A requester must keep valid and payload stable until ready is seen.
- Arbitration (combinational on hold_valid):
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ. The first held slot wins, giving grant[i] one-hot.
  - No grant is issued if no slot is held or squash is high.
- Grant effects at the next edge:
  - cdb_* load the winner's payload; cdb_valid=1; cdb_src_oh=grant.
  - The winner's hold_valid clears, unless a new transfer into the same slot happens in the same cycle, in which case the slot reloads and stays valid.
  - rr_ptr = (winner+1) mod NUM_REQ.
- No grant: cdb_valid=0, cdb_wr_en=0, cdb_src_oh=0, rr_ptr unchanged. Payload outputs hold their last value.
- Latency:
  - Result presented at cycle t with an empty slot -> on CDB in cycle t+2.
  - Throughput is 1 broadcast/cycle.
  - With all NUM_REQ slots busy, each requester is served at least once every NUM_REQ cycles (starvation-free).
- Destination 0: still broadcast with cdb_valid=1, cdb_wr_en=0, so the ROB completes the entry without a register write.
- Squash:
  - At the next edge all hold_valid clear and cdb_valid/cdb_src_oh clear.
  - No transfers are accepted in the squash cycle.
  - rr_ptr is unchanged.
- Reset mid-operation: all held results are lost immediately. Outputs are 0 asynchronously.
- Simultaneous events:
  - Grant and refill of the same slot resolve as above.
  - Squash overrides grant and refill.

Decomposition:
- Shared package:
  - CDB_PACKET typedef (valid, wr_en, dest_idx, data, rob_idx, src_oh).
  - CDB_REQ_PACKET typedef (dest_idx, data, rob_idx).
  - NUM_CDB_REQ constant.
- Sub-module rr_arbiter: NUM_REQ request vector in, one-hot grant out, with an internal rr_ptr register (same clock/reset). Instantiated once; reusable for the RS issue select.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-cycle with slots 0,2 held.
  - Required: immediately cdb_valid=0 and req_ready=0; after release req_ready=4'b1111 and no broadcasts.
- Single result:
  - Stimulus: requester 1 offers dest=5, data=0xDEADBEEF, rob=3 at cycle t.
  - Required: req_ready[1]=1; at t+2 cdb_valid=1, cdb_wr_en=1, cdb_src_oh=4'b0010; at t+3 cdb_valid=0.
- Four-way collision:
  - Stimulus: all four requesters valid in the same cycle, rr_ptr=0, then each keeps offering.
  - Required: broadcast order 0,1,2,3,0,...; after slots fill, each req_ready[i] is 1 only in the cycle its slot is granted.
- Grant and refill same slot:
  - Stimulus: requester 2 streams rob=7,8,9 back-to-back with the others idle.
  - Required: CDB shows rob 7,8,9 on consecutive cycles with no bubble.
- Zero destination:
  - Stimulus: requester 0 offers dest=0, rob=12.
  - Required: cdb_valid=1, cdb_wr_en=0, cdb_rob_idx=12.
- Squash:
  - Stimulus: slots 0 and 3 held; squash pulsed for one cycle while requester 1 is valid.
  - Required: next cycle cdb_valid=0, no hold_valid set, req_ready=0 during squash; requester 1 is accepted the cycle after and broadcast 2 cycles later.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared constants and packet types for the common data bus
//               (CDB) arbiter and its users (complete stage, ROB, RS wakeup).
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int NUM_CDB_REQ = 4;   // completion requesters sharing the CDB
    localparam int CDB_XLEN    = 32;  // result data width
    localparam int CDB_PREG_W  = 6;   // physical register index width
    localparam int CDB_ROB_W   = 5;   // ROB index width

    // Payload handed over by a functional unit.
    typedef struct packed {
        logic [CDB_PREG_W-1:0] dest_idx;
        logic [CDB_XLEN-1:0]   data;
        logic [CDB_ROB_W-1:0]  rob_idx;
    } CDB_REQ_PACKET;

    // One broadcast as seen by CDB consumers.
    typedef struct packed {
        logic                   valid;
        logic                   wr_en;
        logic [CDB_PREG_W-1:0]  dest_idx;
        logic [CDB_XLEN-1:0]    data;
        logic [CDB_ROB_W-1:0]   rob_idx;
        logic [NUM_CDB_REQ-1:0] src_oh;
    } CDB_PACKET;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Requester handshake plus CDB broadcast bundle.
//               master : functional-unit / consumer side (drives requests)
//               slave  : arbiter side (drives req_ready and the CDB)
// Ports       : req_valid/req_ready/req_dest_idx/req_data/req_rob_idx,
//               cdb_valid/cdb_wr_en/cdb_dest_idx/cdb_data/cdb_rob_idx/cdb_src_oh
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_REQ = cdb_arbiter_pkg::NUM_CDB_REQ,
    parameter int XLEN    = cdb_arbiter_pkg::CDB_XLEN,
    parameter int PREG_W  = cdb_arbiter_pkg::CDB_PREG_W,
    parameter int ROB_W   = cdb_arbiter_pkg::CDB_ROB_W
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][PREG_W-1:0] req_dest_idx;
    logic [NUM_REQ-1:0][XLEN-1:0]   req_data;
    logic [NUM_REQ-1:0][ROB_W-1:0]  req_rob_idx;

    logic                           cdb_valid;
    logic                           cdb_wr_en;
    logic [PREG_W-1:0]              cdb_dest_idx;
    logic [XLEN-1:0]                cdb_data;
    logic [ROB_W-1:0]               cdb_rob_idx;
    logic [NUM_REQ-1:0]             cdb_src_oh;

    modport master (
        output req_valid, req_dest_idx, req_data, req_rob_idx,
        input  req_ready,
        input  cdb_valid, cdb_wr_en, cdb_dest_idx, cdb_data, cdb_rob_idx, cdb_src_oh
    );

    modport slave (
        input  req_valid, req_dest_idx, req_data, req_rob_idx,
        output req_ready,
        output cdb_valid, cdb_wr_en, cdb_dest_idx, cdb_data, cdb_rob_idx, cdb_src_oh
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The search starts at the internal
//               pointer and wraps upward; the pointer moves just past the
//               winner whenever a grant is issued.
// Ports       : clk, rst (async, active-high)
//               i_req   [NUM_REQ] request vector
//               o_grant [NUM_REQ] one-hot grant (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant
);
    localparam logic [IDX_W:0]   c_num  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last = IDX_W'(NUM_REQ-1);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W:0]   w_sum;
    logic             w_found;

    // One extra bit on the sum keeps the wrap correct for non power-of-two
    // requester counts (ptr + k < 2*NUM_REQ, so a single subtract suffices).
    always_comb begin
        o_grant   = '0;
        w_found   = 1'b0;
        w_win_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                w_found         = 1'b1;
                w_win_idx       = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win_idx == c_last) ? '0 : w_win_idx + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Shares the common data bus between NUM_REQ functional-unit
//               completion ports. Each port fills a one-entry holding slot
//               through valid/ready; a round-robin arbiter broadcasts one
//               held result per cycle on registered CDB outputs.
// Ports       : clock, reset (async, active-high), squash (sync flush)
//               bus : cdb_arbiter_if.slave (request handshake + CDB outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_CDB_REQ,
    parameter int XLEN      = CDB_XLEN,
    parameter int PREG_W    = CDB_PREG_W,
    parameter int ROB_W     = CDB_ROB_W,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [PREG_W-1:0] dest_idx;
        logic [XLEN-1:0]   data;
        logic [ROB_W-1:0]  rob_idx;
    } slot_t;

    logic [NUM_REQ-1:0] r_hold_valid;
    slot_t              r_slot [NUM_REQ];

    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_take;
    logic               w_any_grant;
    slot_t              w_win;

    logic               r_cdb_valid;
    logic               r_cdb_wr_en;
    logic [PREG_W-1:0]  r_cdb_dest_idx;
    logic [XLEN-1:0]    r_cdb_data;
    logic [ROB_W-1:0]   r_cdb_rob_idx;
    logic [NUM_REQ-1:0] r_cdb_src_oh;

    // Squash masks the requests, so no grant and no pointer movement occur.
    assign w_arb_req   = r_hold_valid & {NUM_REQ{~squash}};
    assign w_any_grant = |w_grant;

    // A slot being granted this cycle frees up in time to take a new result
    // at the same edge, which gives back-to-back streaming from one port.
    assign w_req_ready = {NUM_REQ{~squash & ~reset}} & (~r_hold_valid | w_grant);
    assign w_take      = bus.req_valid & w_req_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_rr_arbiter (
        .clk     (clock),
        .rst     (reset),
        .i_req   (w_arb_req),
        .o_grant (w_grant)
    );

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_win = r_slot[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_slot[i] <= '0;
            end
        end else if (squash) begin
            r_hold_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_take[i]) begin
                    r_hold_valid[i]   <= 1'b1;
                    r_slot[i].dest_idx <= bus.req_dest_idx[i];
                    r_slot[i].data     <= bus.req_data[i];
                    r_slot[i].rob_idx  <= bus.req_rob_idx[i];
                end else if (w_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload registers keep their last value when idle; only the qualifiers
    // (valid, wr_en, src_oh) drop back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cdb_valid    <= 1'b0;
            r_cdb_wr_en    <= 1'b0;
            r_cdb_dest_idx <= '0;
            r_cdb_data     <= '0;
            r_cdb_rob_idx  <= '0;
            r_cdb_src_oh   <= '0;
        end else begin
            r_cdb_valid  <= w_any_grant;
            r_cdb_wr_en  <= w_any_grant & (w_win.dest_idx != '0);
            r_cdb_src_oh <= w_grant;
            if (w_any_grant) begin
                r_cdb_dest_idx <= w_win.dest_idx;
                r_cdb_data     <= w_win.data;
                r_cdb_rob_idx  <= w_win.rob_idx;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.cdb_valid    = r_cdb_valid;
    assign bus.cdb_wr_en    = r_cdb_wr_en;
    assign bus.cdb_dest_idx = r_cdb_dest_idx;
    assign bus.cdb_data     = r_cdb_data;
    assign bus.cdb_rob_idx  = r_cdb_rob_idx;
    assign bus.cdb_src_oh   = r_cdb_src_oh;
endmodule
`default_nettype wire
